// File: rtl/fifo_stream_rd_if.sv
// fifo_stream_rd_if: FIFO read port plus valid/ready stream, grouped for the
// fifo_stream_rd adapter. The master side is the adapter: it drives the FIFO pop
// strobe and the stream outputs. The slave side is the FIFO and the consumer.
interface fifo_stream_rd_if #(
    parameter int DATAWIDTH = 8
);
    logic                 fifo_empty;
    logic                 fifo_read;
    logic [DATAWIDTH-1:0] fifo_dout;
    logic                 m_valid;
    logic                 m_ready;
    logic [DATAWIDTH-1:0] m_data;
    logic                 m_last;

    modport master (
        input  fifo_empty,
        output fifo_read,
        input  fifo_dout,
        output m_valid,
        input  m_ready,
        output m_data,
        output m_last
    );

    modport slave (
        output fifo_empty,
        input  fifo_read,
        output fifo_dout,
        input  m_valid,
        output m_ready,
        input  m_data,
        input  m_last
    );
endinterface

// File: rtl/fifo_stream_rd.sv
// fifo_stream_rd: drains the read port of a dual-clock FIFO, which has
// registered flags and a registered read address, and presents the words as a
// valid/ready stream. After each pop the FIFO's empty flag and dout are stale
// for one cycle, so the FSM waits one cycle (SETTLE) before it may pop again.
// A 2-entry buffer absorbs consumer backpressure.
//
// Optional feature macro: FIFO_RD_EOS_EN. When it is defined, fifo_dout MSB is an
// end-of-stream flag. It is reported on m_last and masked off m_data. Popping a
// flagged word parks the FSM in HALT until flush.
//
// state  | meaning
// CHECK  | may pop if FIFO non-empty and buffer has room
// SETTLE | one-cycle wait after a pop, reset or flush (FIFO flags stale)
// HALT   | end-of-stream seen; no further pops until flush (EOS builds only)
module fifo_stream_rd #(
    parameter int DATAWIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    output logic [15:0]      word_count,
    fifo_stream_rd_if.master bus
);

    typedef enum logic [1:0] {
        ST_CHECK  = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HALT   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_fifo_read;
    logic                 w_pop;
    logic                 w_eos_in;
    logic [DATAWIDTH-1:0] r_entry [2];
    logic                 r_rd_idx;
    logic                 r_wr_idx;
    logic [1:0]           r_count;
    logic [15:0]          r_word_count;
    logic [DATAWIDTH-1:0] w_head;

`ifdef FIFO_RD_EOS_EN
    assign w_eos_in = bus.fifo_dout[DATAWIDTH-1];
`else
    assign w_eos_in = 1'b0;
`endif

    // A consumer pop is discarded while flush is high.
    assign w_pop = (r_count != 2'd0) && bus.m_ready && !flush;

    // Next-state and pop strobe; pops only from CHECK, and never into a full buffer.
    always_comb begin
        w_state_nxt = r_state;
        w_fifo_read = 1'b0;
        if (flush) begin
            w_state_nxt = ST_SETTLE;
        end else begin
            case (r_state)
                ST_CHECK: begin
                    if (!bus.fifo_empty && (r_count < 2'd2)) begin
                        w_fifo_read = 1'b1;
                        w_state_nxt = w_eos_in ? ST_HALT : ST_SETTLE;
                    end
                end
                ST_SETTLE: w_state_nxt = ST_CHECK;
                ST_HALT:   w_state_nxt = ST_HALT;
                default:   w_state_nxt = ST_SETTLE;
            endcase
        end
    end

    // State register; reset lands in SETTLE because the FIFO empty flag is not yet valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_SETTLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output buffer, indices, occupancy and accepted-word counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_entry[0]   <= '0;
            r_entry[1]   <= '0;
            r_rd_idx     <= 1'b0;
            r_wr_idx     <= 1'b0;
            r_count      <= 2'd0;
            r_word_count <= 16'd0;
        end else if (flush) begin
            r_rd_idx     <= 1'b0;
            r_wr_idx     <= 1'b0;
            r_count      <= 2'd0;
            r_word_count <= 16'd0;
        end else begin
            if (w_fifo_read) begin
                r_entry[r_wr_idx] <= bus.fifo_dout;
                r_wr_idx          <= ~r_wr_idx;
            end
            if (w_pop) begin
                r_rd_idx     <= ~r_rd_idx;
                r_word_count <= r_word_count + 16'd1;
            end
            case ({w_fifo_read, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head        = r_entry[r_rd_idx];
    assign bus.fifo_read = w_fifo_read;
    assign bus.m_valid   = (r_count != 2'd0);
    assign word_count    = r_word_count;

`ifdef FIFO_RD_EOS_EN
    assign bus.m_data = {1'b0, w_head[DATAWIDTH-2:0]};
    assign bus.m_last = w_head[DATAWIDTH-1];
`else
    assign bus.m_data = w_head;
    assign bus.m_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_rd.sv
// Directed bench for fifo_stream_rd. A queue models the FIFO contents. Every
// word loaded into the FIFO model also pushes its expected stream output to a
// scoreboard queue. The scoreboard is popped whenever the consumer accepts a word.
module tb_fifo_stream_rd;
    localparam int DW = 9;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] word_count;

    fifo_stream_rd_if #(.DATAWIDTH(DW)) ifc();

    fifo_stream_rd #(.DATAWIDTH(DW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .word_count (word_count),
        .bus        (ifc.master)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    int pops = 0;

    logic [DW-1:0] fifo_q [$];
    logic [DW:0]   exp_q [$];

    logic          s_rd, s_vld, s_acc, s_last;
    logic [DW-1:0] s_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected {m_last, m_data} for a word written into the FIFO.
    function automatic logic [DW:0] expect_of(input logic [DW-1:0] w);
`ifdef FIFO_RD_EOS_EN
        return {w[DW-1], 1'b0, w[DW-2:0]};
`else
        return {1'b0, w};
`endif
    endfunction

    task automatic load(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(expect_of(w));
        ifc.fifo_empty = 1'b0;
        ifc.fifo_dout  = fifo_q[0];
    endtask

    // One clock: sample on the falling edge, score accepts, then update the FIFO model after the edge.
    task automatic cycle();
        logic [DW:0] e;
        @(negedge clk);
        s_rd   = ifc.fifo_read;
        s_vld  = ifc.m_valid;
        s_acc  = ifc.m_valid && ifc.m_ready && !flush;
        s_data = ifc.m_data;
        s_last = ifc.m_last;
        if (s_rd) pops++;
        if (s_acc) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_data", 32'(s_data), 32'(e[DW-1:0]));
                check("sb_last", 32'(s_last), 32'(e[DW]));
            end
        end
        @(posedge clk);
        #1;
        if (s_rd) begin
            check("fifo_underflow", 32'(fifo_q.size() != 0), 32'd1);
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        end
        ifc.fifo_empty = (fifo_q.size() == 0);
        ifc.fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW:0] e;
        ifc.fifo_empty = 1'b1;
        ifc.fifo_dout  = '0;
        ifc.m_ready    = 1'b1;

        // Reset with FIFO non-empty
        load(9'h011); load(9'h012); load(9'h013); load(9'h014);
        reset_n = 1'b0;
        repeat (2) cycle();
        check("rst_rd",    32'(s_rd), 32'd0);
        check("rst_vld",   32'(ifc.m_valid), 32'd0);
        check("rst_data",  32'(ifc.m_data), 32'd0);
        check("rst_last",  32'(ifc.m_last), 32'd0);
        check("rst_wc",    32'(word_count), 32'd0);
        reset_n = 1'b1;
        cycle();
        check("rst_first_rd",  32'(s_rd), 32'd0);
        check("rst_first_vld", 32'(s_vld), 32'd0);

        // Streaming: pop every other cycle, data valid the cycle after each pop
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("stream_rd",  32'(s_rd),  32'((i % 2) == 0));
            check("stream_vld", 32'(s_vld), 32'((i % 2) == 1));
        end
        repeat (2) cycle();
        check("stream_wc", 32'(word_count), 32'd4);
        check("stream_drained", 32'(exp_q.size()), 32'd0);

        // Single word brings word_count to 5
        load(9'h031);
        cycle();
        check("single_rd_comb", 32'(s_rd), 32'd1);
        repeat (2) cycle();
        check("single_wc", 32'(word_count), 32'd5);

        // Flush with a full buffer and a word still in the FIFO
        ifc.m_ready = 1'b0;
        load(9'h041); load(9'h042); load(9'h043);
        repeat (5) cycle();
        check("fl_pre_wc",  32'(word_count), 32'd5);
        check("fl_pre_vld", 32'(s_vld), 32'd1);
        check("fl_pre_rd",  32'(s_rd), 32'd0);
        flush = 1'b1;
        ifc.m_ready = 1'b1;
        cycle();
        check("fl_rd_flush", 32'(s_rd), 32'd0);
        flush = 1'b0;
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        check("fl_wc",  32'(word_count), 32'd0);
        check("fl_vld", 32'(ifc.m_valid), 32'd0);
        cycle();
        check("fl_rd_after", 32'(s_rd), 32'd0);
        cycle();
        check("fl_resume_rd", 32'(s_rd), 32'd1);
        repeat (2) cycle();
        check("fl_post_wc", 32'(word_count), 32'd1);

        // Backpressure: 3 words, consumer stalled
        ifc.m_ready = 1'b0;
        pops = 0;
        load(9'h021); load(9'h022); load(9'h023);
        repeat (6) cycle();
        e = expect_of(9'h021);
        check("bp_pops",    32'(pops), 32'd2);
        check("bp_rd_held", 32'(s_rd), 32'd0);
        check("bp_vld",     32'(s_vld), 32'd1);
        check("bp_data",    32'(s_data), 32'(e[DW-1:0]));
        ifc.m_ready = 1'b1;
        cycle();
        check("bp_no_pop_full", 32'(s_rd), 32'd0);
        cycle();
        check("bp_pop3", 32'(s_rd), 32'd1);
        repeat (2) cycle();
        check("bp_drained", 32'(exp_q.size()), 32'd0);
        check("bp_wc", 32'(word_count), 32'd4);

        // Simultaneous push and consumer pop at count 1
        ifc.m_ready = 1'b0;
        load(9'h0A1); load(9'h0A2);
        repeat (2) cycle();
        ifc.m_ready = 1'b1;
        cycle();
        check("pp_rd",  32'(s_rd), 32'd1);
        check("pp_acc", 32'(s_acc), 32'd1);
        cycle();
        e = expect_of(9'h0A2);
        check("pp_vld",  32'(s_vld), 32'd1);
        check("pp_data", 32'(s_data), 32'(e[DW-1:0]));
        cycle();
        check("pp_wc", 32'(word_count), 32'd6);

        // End-of-stream flag word
        pops = 0;
        load(9'h1A5); load(9'h1B0);
        cycle();
        check("eos_rd", 32'(s_rd), 32'd1);
        cycle();
`ifdef FIFO_RD_EOS_EN
        check("eos_data", 32'(s_data), 32'h0A5);
        check("eos_last", 32'(s_last), 32'd1);
`else
        check("eos_data", 32'(s_data), 32'h1A5);
        check("eos_last", 32'(s_last), 32'd0);
`endif
        repeat (6) cycle();
`ifdef FIFO_RD_EOS_EN
        check("eos_pops", 32'(pops), 32'd1);
`else
        check("eos_pops", 32'(pops), 32'd2);
`endif
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        repeat (4) cycle();
        check("end_sb_empty",   32'(exp_q.size()), 32'd0);
        check("end_fifo_empty", 32'(fifo_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
